// File: rtl/fp_vector_driver_if.sv
// Bundle of the driver's ROM, adder, result-buffer and status signals.
// The driver side connects to master; the ROM, adder and host side connect to slave.
interface fp_vector_driver_if;
    logic        start;
    logic [3:0]  address;
    logic [63:0] mem_content;
    logic [31:0] num_a;
    logic [31:0] num_b;
    logic        operands_valid;
    logic [31:0] result;
    logic [3:0]  res_addr;
    logic [31:0] res_data;
    logic        busy;
    logic        done;
    logic [3:0]  err_count;

    modport master (
        input  start, mem_content, result, res_addr,
        output address, num_a, num_b, operands_valid, res_data, busy, done, err_count
    );

    modport slave (
        output start, mem_content, result, res_addr,
        input  address, num_a, num_b, operands_valid, res_data, busy, done, err_count
    );
endinterface

// File: rtl/fp_vector_driver.sv
// Walks the operand ROM, issues A/B pairs to an FP adder and buffers each sum.
// Optional Inf/NaN result counting is enabled with the FP_DRIVER_CHECK_EN macro.
module fp_vector_driver #(
    parameter int NUM_VECTORS   = 11,
    parameter int ADDER_LATENCY = 2
) (
    input logic                 clk,
    input logic                 reset,
    fp_vector_driver_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_MEMWAIT, S_ISSUE, S_WAIT, S_DONE
    } state_t;

    localparam logic [3:0] LAST_IDX  = 4'(NUM_VECTORS - 1);
    localparam logic [3:0] WAIT_INIT = 4'(ADDER_LATENCY - 1);
    localparam logic [4:0] NV        = 5'(NUM_VECTORS);

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  addr_q;
    logic [3:0]  wait_q;
    logic [31:0] num_a_q;
    logic [31:0] num_b_q;
    logic        opv_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] res_data_q;
    logic [31:0] buf_q [16];

    logic [3:0]  idx_d;
    logic        start_ok;
    logic        last_wait;

    assign idx_d     = idx_q + 4'd1;
    assign start_ok  = bus.start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_wait = (state_q == S_WAIT) && (wait_q == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wait_q  <= '0;
            num_a_q <= '0;
            num_b_q <= '0;
            opv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            opv_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        idx_q   <= '0;
                        addr_q  <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: state_q <= S_MEMWAIT;
                S_MEMWAIT: begin
                    num_a_q <= bus.mem_content[63:32];
                    num_b_q <= bus.mem_content[31:0];
                    opv_q   <= 1'b1;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    wait_q  <= WAIT_INIT;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q != 4'd0) begin
                        wait_q <= wait_q - 4'd1;
                    end else if (idx_q == LAST_IDX) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        // Address advances in step with the index so it never passes the last entry.
                        idx_q   <= idx_d;
                        addr_q  <= idx_d;
                        state_q <= S_ADDR;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read port uses pre-write contents, so a same-cycle read sees the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) buf_q[i] <= '0;
            res_data_q <= '0;
        end else begin
            if (last_wait) buf_q[idx_q] <= bus.result;
            res_data_q <= ({1'b0, bus.res_addr} < NV) ? buf_q[bus.res_addr] : '0;
        end
    end

`ifdef FP_DRIVER_CHECK_EN
    logic [3:0] err_q;
    logic [3:0] err_d;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_comb begin
        err_d = err_q;
        if (start_ok)
            err_d = '0;
        else if (last_wait && (bus.result[30:23] == 8'hFF))
            err_d = sat_inc(err_q);
    end

    always_ff @(posedge clk) begin
        if (reset) err_q <= '0;
        else       err_q <= err_d;
    end

    assign bus.err_count = err_q;
`else
    assign bus.err_count = '0;
`endif

    assign bus.address        = addr_q;
    assign bus.num_a          = num_a_q;
    assign bus.num_b          = num_b_q;
    assign bus.operands_valid = opv_q;
    assign bus.res_data       = res_data_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
endmodule

// File: tb/tb_fp_vector_driver.sv
// Directed bench for fp_vector_driver: ROM and adder are table-driven models
// with hand-computed single-precision sums.
module tb_fp_vector_driver;
    logic clk = 1'b0;
    logic reset;
    logic force_inf;
    int   ntests = 0;
    int   nfail  = 0;

    always #5 clk = ~clk;

`ifdef FP_DRIVER_CHECK_EN
    localparam logic [31:0] EXP_ERR = 32'd2;
`else
    localparam logic [31:0] EXP_ERR = 32'd0;
`endif

    logic [63:0] rom [16];
    logic [31:0] sum [16];

    fp_vector_driver_if b1();
    fp_vector_driver_if b2();

    fp_vector_driver #(.NUM_VECTORS(11), .ADDER_LATENCY(2)) dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );
    fp_vector_driver #(.NUM_VECTORS(1), .ADDER_LATENCY(1)) dut2 (
        .clk(clk), .reset(reset), .bus(b2)
    );

    function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic frc);
        for (int i = 0; i < 11; i++)
            if (rom[i] == {a, b})
                return (frc && (i == 3 || i == 6)) ? 32'h7f800000 : sum[i];
        return 32'hdeadbeef;
    endfunction

    always @(posedge clk) b1.mem_content <= reset ? 64'd0 : rom[b1.address];
    always @(posedge clk) b2.mem_content <= reset ? 64'd0 : rom[b2.address];
    always_comb b1.result = add_model(b1.num_a, b1.num_b, force_inf);
    always_comb b2.result = add_model(b2.num_a, b2.num_b, 1'b0);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd1(input logic [3:0] a, input logic [31:0] exp, input string tag);
        b1.res_addr = a;
        tick();
        check(tag, b1.res_data, exp);
    endtask

    int          cycles;
    int          inj;
    int          opv_cnt [16];
    logic [3:0]  maxa;
    logic [31:0] a0, bb0;

    initial begin
        rom = '{64'h3f800000_40000000, 64'hbf800000_3f800000, 64'h40000000_40000000,
                64'h40400000_3f800000, 64'h3f000000_3f000000, 64'h40800000_40800000,
                64'h41000000_3f800000, 64'h40a00000_3f800000, 64'h40000000_c0000000,
                64'h40400000_40000000, 64'h3f800000_3f800000, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        sum = '{32'h40400000, 32'h00000000, 32'h40800000, 32'h40800000, 32'h3f800000,
                32'h41000000, 32'h41100000, 32'h40c00000, 32'h00000000, 32'h40a00000,
                32'h40000000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        reset = 1'b1; force_inf = 1'b0;
        b1.start = 1'b0; b1.res_addr = '0;
        b2.start = 1'b0; b2.res_addr = '0;
        for (int i = 0; i < 16; i++) opv_cnt[i] = 0;
        repeat (3) tick();

        check("rst_address", {28'd0, b1.address}, 32'd0);
        check("rst_num_a", b1.num_a, 32'd0);
        check("rst_num_b", b1.num_b, 32'd0);
        check("rst_opv", {31'd0, b1.operands_valid}, 32'd0);
        check("rst_busy", {31'd0, b1.busy}, 32'd0);
        check("rst_done", {31'd0, b1.done}, 32'd0);
        check("rst_res_data", b1.res_data, 32'd0);
        check("rst_err", {28'd0, b1.err_count}, 32'd0);
        reset = 1'b0;
        tick();

        // Full default run with start pulses injected during vector 2's WAIT
        b1.start = 1'b1; tick(); b1.start = 1'b0;
        check("busy_from_E0", {31'd0, b1.busy}, 32'd1);
        cycles = 0; inj = 0; maxa = '0; a0 = '0; bb0 = '0;
        while (!b1.done && cycles < 200) begin
            tick(); cycles++;
            b1.start = (inj > 0);
            if (inj > 0) inj--;
            if (b1.address > maxa) maxa = b1.address;
            if (b1.operands_valid) begin
                opv_cnt[b1.address]++;
                if (b1.address == 4'd0) begin a0 = b1.num_a; bb0 = b1.num_b; end
                if (b1.address == 4'd2) inj = 2;
            end
        end
        b1.start = 1'b0;
        check("done_latency", cycles, 32'd55);
        check("busy_at_done", {31'd0, b1.busy}, 32'd0);
        check("v0_num_a", a0, 32'h3f800000);
        check("v0_num_b", bb0, 32'h40000000);
        check("max_address", {28'd0, maxa}, 32'd10);
        for (int i = 0; i < 11; i++) check($sformatf("opv_count_%0d", i), opv_cnt[i], 32'd1);
        rd1(4'd0, 32'h40400000, "buf0");
        rd1(4'd1, 32'h00000000, "buf1");
        rd1(4'd8, 32'h00000000, "buf8");
        rd1(4'd9, 32'h40a00000, "buf9");
        rd1(4'd10, 32'h40000000, "buf10");
        rd1(4'd6, 32'h41100000, "buf6");
        rd1(4'd11, 32'h00000000, "buf_out_of_range");

        // Second run with Inf forced on vectors 3 and 6
        force_inf = 1'b1;
        b1.start = 1'b1; tick(); b1.start = 1'b0;
        cycles = 0;
        while (!b1.done && cycles < 200) begin tick(); cycles++; end
        force_inf = 1'b0;
        check("run2_latency", cycles, 32'd55);
        check("err_at_done", {28'd0, b1.err_count}, EXP_ERR);
        rd1(4'd3, 32'h7f800000, "buf3_inf");
        rd1(4'd4, 32'h3f800000, "buf4");

        // Restart clears err_count, then reset after vector 4's ISSUE
        b1.start = 1'b1; tick(); b1.start = 1'b0;
        check("restart_err", {28'd0, b1.err_count}, 32'd0);
        check("restart_done", {31'd0, b1.done}, 32'd0);
        check("restart_busy", {31'd0, b1.busy}, 32'd1);
        cycles = 0;
        while (!(b1.operands_valid && b1.address == 4'd4) && cycles < 200) begin tick(); cycles++; end
        check("reach_v4_issue", {31'd0, b1.operands_valid}, 32'd1);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_busy", {31'd0, b1.busy}, 32'd0);
        check("mid_rst_done", {31'd0, b1.done}, 32'd0);
        check("mid_rst_opv", {31'd0, b1.operands_valid}, 32'd0);
        check("mid_rst_address", {28'd0, b1.address}, 32'd0);
        check("mid_rst_num_a", b1.num_a, 32'd0);
        check("mid_rst_res_data", b1.res_data, 32'd0);
        for (int i = 0; i < 11; i++) rd1(4'(i), 32'd0, $sformatf("cleared_buf%0d", i));

        // start together with reset must be ignored
        reset = 1'b1; b1.start = 1'b1; tick();
        reset = 1'b0; b1.start = 1'b0;
        check("start_rst_busy", {31'd0, b1.busy}, 32'd0);
        tick();
        check("start_rst_idle", {31'd0, b1.busy}, 32'd0);
        check("start_rst_done", {31'd0, b1.done}, 32'd0);

        // NUM_VECTORS=1, ADDER_LATENCY=1 instance
        b2.start = 1'b1; tick(); b2.start = 1'b0;
        cycles = 0;
        while (!b2.done && cycles < 50) begin tick(); cycles++; end
        check("nv1_latency", cycles, 32'd4);
        check("nv1_address", {28'd0, b2.address}, 32'd0);
        b2.res_addr = 4'd0; tick();
        check("nv1_buf0", b2.res_data, 32'h40400000);
        b2.res_addr = 4'd1; tick();
        check("nv1_buf1_oob", b2.res_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
